// File: rtl/maze_neighbor_fetch_pkg.sv
// Shared video timing defaults and arm-state type for the maze neighbour window.
// Also holds the coordinate helper that steps a raster position back by one, wrapping at the line or frame total.
package maze_neighbor_fetch_pkg;

    localparam int VID_H_ACTIVE = 640;
    localparam int VID_V_ACTIVE = 480;
    localparam int VID_H_TOTAL  = 800;
    localparam int VID_V_TOTAL  = 525;
    localparam int COORD_W      = 10;

    typedef enum logic {
        ARM_IDLE  = 1'b0,
        ARM_ARMED = 1'b1
    } arm_state_t;

    // Previous raster coordinate, wrapping 0 back to total-1.
    function automatic logic [COORD_W-1:0] prev_coord(
        input logic [COORD_W-1:0] coord,
        input logic [COORD_W-1:0] total
    );
        return (coord == '0) ? (total - 1'b1) : (coord - 1'b1);
    endfunction

endpackage

// File: rtl/maze_line_buffer.sv
// One-bit-wide line memory: asynchronous read, synchronous write, so a read in
// the same cycle as a write to that address returns the old contents.
module maze_line_buffer #(
    parameter int DEPTH = 640
) (
    input  logic       pixel_clk,
    input  logic       we,
    input  logic [9:0] addr,
    input  logic       wdata,
    output logic       rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic mem [0:DEPTH-1];

    always_ff @(posedge pixel_clk) begin
        if (we) begin
            mem[addr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[addr[AW-1:0]];

endmodule

// File: rtl/maze_neighbor_fetch.sv
// Streams the maze wall bitmap through two line buffers and presents the 3x3 cross
// neighbourhood of pixel (DrawX-1, DrawY-1) one pixel_clk after (DrawX, DrawY).
module maze_neighbor_fetch
    import maze_neighbor_fetch_pkg::*;
#(
    parameter int H_ACTIVE = VID_H_ACTIVE,
    parameter int V_ACTIVE = VID_V_ACTIVE,
    parameter int H_TOTAL  = VID_H_TOTAL,
    parameter int V_TOTAL  = VID_V_TOTAL
) (
    input  logic       pixel_clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       mazePix,
    output logic       currentMazePrime,
    output logic       MazeUpPrime,
    output logic       MazeDownPrime,
    output logic       MazeLeftPrime,
    output logic       MazeRightPrime,
    output logic [9:0] CenterX,
    output logic [9:0] CenterY,
    output logic       out_valid
);

    localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    localparam logic [9:0] H_TOT = 10'(H_TOTAL);
    localparam logic [9:0] V_TOT = 10'(V_TOTAL);

    arm_state_t state_reg, state_next;

    logic       in_line;
    logic       in_active;
    logic       pix_eff;
    logic [1:0] buf_wdata;
    logic [1:0] buf_rdata;
    logic       rd_a;
    logic       rd_b;

    logic a_tap0_reg, a_tap1_reg, b_tap_reg, in_tap_reg;

    logic [9:0] cx_next, cy_next;
    logic       valid_next;
    logic       cur_next, up_next, down_next, left_next, right_next;

    assign in_line   = (DrawX < H_ACT);
    assign in_active = in_line && (DrawY < V_ACT);
    assign pix_eff   = in_active ? mazePix : 1'b1;

    // Buffer 0 (A) holds row y-1; its old contents shift into buffer 1 (B), row y-2.
    assign buf_wdata[0] = pix_eff;
    assign buf_wdata[1] = buf_rdata[0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            maze_line_buffer #(
                .DEPTH(H_ACTIVE)
            ) u_buf (
                .pixel_clk(pixel_clk),
                .we       (in_line),
                .addr     (DrawX),
                .wdata    (buf_wdata[gi]),
                .rdata    (buf_rdata[gi])
            );
        end
    endgenerate

    assign rd_a = in_line ? buf_rdata[0] : 1'b1;
    assign rd_b = in_line ? buf_rdata[1] : 1'b1;

    always_ff @(posedge pixel_clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= ARM_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARM_IDLE:  if (DrawX == '0 && DrawY == '0) state_next = ARM_ARMED;
            ARM_ARMED: state_next = ARM_ARMED;
            default:   state_next = ARM_IDLE;
        endcase
    end

    // Window for the centre one pixel up and left; frame edges read as wall.
    always_comb begin
        cx_next    = prev_coord(DrawX, H_TOT);
        cy_next    = prev_coord(DrawY, V_TOT);
        valid_next = (cx_next < H_ACT) && (cy_next < V_ACT) && (state_reg == ARM_ARMED);
        cur_next   = 1'b0;
        up_next    = 1'b0;
        down_next  = 1'b0;
        left_next  = 1'b0;
        right_next = 1'b0;
        if (valid_next) begin
            cur_next   = a_tap0_reg;
            up_next    = b_tap_reg  | (cy_next == '0);
            down_next  = in_tap_reg | (cy_next == V_ACT - 1'b1);
            left_next  = a_tap1_reg | (cx_next == '0);
            right_next = rd_a       | (cx_next == H_ACT - 1'b1);
        end
    end

    always_ff @(posedge pixel_clk or posedge Reset) begin
        if (Reset) begin
            a_tap0_reg       <= 1'b0;
            a_tap1_reg       <= 1'b0;
            b_tap_reg        <= 1'b0;
            in_tap_reg       <= 1'b0;
            CenterX          <= '0;
            CenterY          <= '0;
            out_valid        <= 1'b0;
            currentMazePrime <= 1'b0;
            MazeUpPrime      <= 1'b0;
            MazeDownPrime    <= 1'b0;
            MazeLeftPrime    <= 1'b0;
            MazeRightPrime   <= 1'b0;
        end else begin
            a_tap0_reg       <= rd_a;
            a_tap1_reg       <= a_tap0_reg;
            b_tap_reg        <= rd_b;
            in_tap_reg       <= pix_eff;
            CenterX          <= cx_next;
            CenterY          <= cy_next;
            out_valid        <= valid_next;
            currentMazePrime <= cur_next;
            MazeUpPrime      <= up_next;
            MazeDownPrime    <= down_next;
            MazeLeftPrime    <= left_next;
            MazeRightPrime   <= right_next;
        end
    end

endmodule

// File: tb/tb_maze_neighbor_fetch.sv
// Scoreboard bench for maze_neighbor_fetch on a reduced raster; expected windows
// come from a stored picture of the frame, not from the buffer mechanics.
module tb_maze_neighbor_fetch;

    localparam int HA = 16;
    localparam int VA = 12;
    localparam int HT = 20;
    localparam int VT = 14;

    logic       pixel_clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY;
    logic       mazePix;
    logic       currentMazePrime, MazeUpPrime, MazeDownPrime, MazeLeftPrime, MazeRightPrime;
    logic [9:0] CenterX, CenterY;
    logic       out_valid;

    always #5 pixel_clk = ~pixel_clk;

    maze_neighbor_fetch #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT)
    ) dut (
        .pixel_clk       (pixel_clk),
        .Reset           (Reset),
        .DrawX           (DrawX),
        .DrawY           (DrawY),
        .mazePix         (mazePix),
        .currentMazePrime(currentMazePrime),
        .MazeUpPrime     (MazeUpPrime),
        .MazeDownPrime   (MazeDownPrime),
        .MazeLeftPrime   (MazeLeftPrime),
        .MazeRightPrime  (MazeRightPrime),
        .CenterX         (CenterX),
        .CenterY         (CenterY),
        .out_valid       (out_valid)
    );

    typedef struct packed {
        logic       valid;
        logic [9:0] cx;
        logic [9:0] cy;
        logic [4:0] win;   // cur, up, down, left, right
    } win_t;

    win_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic frame_pix [0:VA-1][0:HA-1];
    bit   armed_m = 1'b0;
    bit   check_data = 1'b1;
    int   valid_seen = 0;

    function automatic logic eff(input int x, input int y);
        if (x < 0 || y < 0 || x >= HA || y >= VA) return 1'b1;
        return frame_pix[y][x];
    endfunction

    task automatic fill(input int kind);
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                case (kind)
                    1:       frame_pix[y][x] = (x == 5 && y == 4);
                    2:       frame_pix[y][x] = (x == 8);
                    3:       frame_pix[y][x] = 1'($urandom_range(0, 1));
                    default: frame_pix[y][x] = 1'b0;
                endcase
    endtask

    task automatic drive_pixel(input int x, input int y, input logic p);
        win_t e, got;
        int cx, cy;
        DrawX   = 10'(x);
        DrawY   = 10'(y);
        mazePix = p;
        cx = (x == 0) ? HT - 1 : x - 1;
        cy = (y == 0) ? VT - 1 : y - 1;
        e = '0;
        if (!Reset) begin
            e.cx    = 10'(cx);
            e.cy    = 10'(cy);
            e.valid = armed_m && cx < HA && cy < VA;
            if (e.valid)
                e.win = {eff(cx, cy), eff(cx, cy - 1), eff(cx, cy + 1), eff(cx - 1, cy), eff(cx + 1, cy)};
            if (x == 0 && y == 0) armed_m = 1'b1;
        end
        exp_q.push_back(e);
        @(posedge pixel_clk);
        #1;
        got.valid = out_valid;
        got.cx    = CenterX;
        got.cy    = CenterY;
        got.win   = {currentMazePrime, MazeUpPrime, MazeDownPrime, MazeLeftPrime, MazeRightPrime};
        e = exp_q.pop_front();
        checks++;
        if (got.cx !== e.cx || got.cy !== e.cy) begin
            failures++;
            $display("FAIL centre in=(%0d,%0d) got=(%0d,%0d) exp=(%0d,%0d)", x, y, got.cx, got.cy, e.cx, e.cy);
        end
        if (check_data) begin
            checks++;
            if (got.valid !== e.valid || got.win !== e.win) begin
                failures++;
                $display("FAIL window in=(%0d,%0d) got valid=%b cudlr=%b exp valid=%b cudlr=%b",
                         x, y, got.valid, got.win, e.valid, e.win);
            end
        end
        if (got.valid === 1'b1) valid_seen++;
    endtask

    task automatic run_frame(input int rst_line, input bit rand_blank);
        valid_seen = 0;
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < HT; x++) begin
                logic p;
                if (y == rst_line && x == 3) begin
                    Reset = 1'b1;
                    armed_m = 1'b0;
                    #1;
                    checks++;
                    if ({out_valid, CenterX, CenterY, currentMazePrime, MazeUpPrime, MazeDownPrime,
                         MazeLeftPrime, MazeRightPrime} !== '0) begin
                        failures++;
                        $display("FAIL async_reset got valid=%b cx=%0d cy=%0d exp all zero", out_valid, CenterX, CenterY);
                    end
                end
                if (y == rst_line && x == 5) Reset = 1'b0;
                if (x < HA && y < VA) p = frame_pix[y][x];
                else p = rand_blank ? 1'($urandom_range(0, 1)) : 1'b0;
                drive_pixel(x, y, p);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        fill(0);
        drive_pixel(7, 3, 1'b1);
        drive_pixel(0, 0, 1'b0);
        drive_pixel(2, 2, 1'b1);
        Reset = 1'b0;
        for (int x = 10; x < HT; x++) drive_pixel(x, VT - 1, 1'b0);
    endtask

    task automatic test_all_zero();
        fill(0);
        run_frame(-1, 1'b0);
        checks++;
        if (valid_seen != HA * VA) begin
            failures++;
            $display("FAIL valid_count got=%0d exp=%0d", valid_seen, HA * VA);
        end
    endtask

    task automatic test_single_wall();
        fill(1);
        run_frame(-1, 1'b1);
    endtask

    task automatic test_vertical_column();
        fill(2);
        run_frame(-1, 1'b1);
    endtask

    task automatic test_blanking();
        fill(3);
        run_frame(-1, 1'b0);
    endtask

    task automatic test_midframe_reset();
        fill(3);
        run_frame(6, 1'b1);
        checks++;
        if (valid_seen != 5 * HA + 2) begin
            failures++;
            $display("FAIL reset_valid_count got=%0d exp=%0d", valid_seen, 5 * HA + 2);
        end
        fill(3);
        run_frame(-1, 1'b1);
        checks++;
        if (valid_seen != HA * VA) begin
            failures++;
            $display("FAIL resume_valid_count got=%0d exp=%0d", valid_seen, HA * VA);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            fill(3);
            run_frame(-1, 1'b1);
        end
    endtask

    task automatic test_jump();
        check_data = 1'b0;
        for (int i = 0; i < 24; i++)
            drive_pixel(int'($urandom_range(0, HT - 1)), int'($urandom_range(1, VT - 1)), 1'($urandom_range(0, 1)));
        check_data = 1'b1;
        fill(3);
        run_frame(-1, 1'b1);
    endtask

    initial begin
        Reset   = 1'b1;
        DrawX   = '0;
        DrawY   = '0;
        mazePix = 1'b0;
        #1;
        test_reset();
        test_all_zero();
        test_single_wall();
        test_vertical_column();
        test_blanking();
        test_midframe_reset();
        test_back_to_back();
        test_jump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maze_neighbor_fetch.md
MAZE_NEIGHBOR_FETCH -- requirements
Module: maze_neighbor_fetch

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter H_TOTAL, default 800, pixel counts per line including blanking.
REQ-004 SHALL have parameter V_TOTAL, default 525, lines per frame including blanking.
REQ-005 SHALL have port pixel_clk  input  1  pixel clock; all state on its rising edge.
REQ-006 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port DrawX  input  10  raster column, 0..H_TOTAL-1.
REQ-008 SHALL have port DrawY  input  10  raster line, 0..V_TOTAL-1.
REQ-009 SHALL have port mazePix  input  1  wall bit at (DrawX,DrawY), same cycle; don't-care outside the active area.
REQ-010 SHALL have port currentMazePrime  output  1  wall bit at the centre pixel.
REQ-011 SHALL have ports MazeUpPrime, MazeDownPrime, MazeLeftPrime, MazeRightPrime  output  1 each  wall bits at (cx,cy-1), (cx,cy+1), (cx-1,cy), (cx+1,cy).
REQ-012 SHALL have ports CenterX, CenterY  output  10 each  centre coordinates (cx,cy).
REQ-013 SHALL have port out_valid  output  1  centre lies inside the active area and the window is trustworthy.

Function
REQ-014 Input pixels outside the active area (DrawX>=H_ACTIVE or DrawY>=V_ACTIVE) SHALL be treated as wall=1.
REQ-015 Line buffer A SHALL hold row y-1 and line buffer B row y-2; each is H_ACTIVE x 1 bit, indexed by DrawX.
REQ-016 Per cycle with DrawX<H_ACTIVE: read A[DrawX] and B[DrawX], then write B[DrawX]=old A[DrawX] and A[DrawX]=effective input; read-during-write SHALL return old data.
REQ-017 A 3-tap shift register SHALL hold A reads at x, x-1, x-2; a 1-tap register SHALL hold the B read and the effective input; reads at DrawX>=H_ACTIVE SHALL yield 1.
REQ-018 For input at (x,y), the centre SHALL be (x-1,y-1); x=0 maps to cx=H_TOTAL-1 and y=0 maps to cy=V_TOTAL-1.
REQ-019 Outputs SHALL be registered, with exactly 1 pixel_clk latency from input (x,y) to the window for centre (x-1,y-1).
REQ-020 Neighbour mapping: current=A[x-1], left=A[x-2], right=A[x], up=B[x-1], down=input[x-1].
REQ-021 Edge forcing SHALL apply: up=1 when cy=0, down=1 when cy=V_ACTIVE-1, left=1 when cx=0, right=1 when cx=H_ACTIVE-1, regardless of buffer contents.
REQ-022 out_valid SHALL be 1 iff cx<H_ACTIVE, cy<V_ACTIVE, and armed=1.
REQ-023 Neighbour outputs SHALL be 0 whenever out_valid=0.
REQ-024 armed SHALL be a 2-state FSM: IDLE->ARMED on a sampled DrawX==0 && DrawY==0; ARMED holds until Reset.
REQ-025 A non-monotonic DrawX or DrawY jump SHALL NOT corrupt the FSM; the data is then don't-care until the next frame.

Reset
REQ-026 On Reset, all outputs, CenterX, CenterY, the shift taps and armed SHALL go to 0 (FSM IDLE), asynchronously.
REQ-027 Line buffer contents SHALL NOT be reset; edge forcing plus arming guarantees no stale data is visible.
REQ-028 Reset asserted mid-frame SHALL hold out_valid=0 until the next frame origin after release.

Structure
REQ-029 H_ACTIVE, V_ACTIVE, H_TOTAL, V_TOTAL and the arm-state enum SHALL live in the shared video/maze package.
REQ-030 One sub-module, maze_line_buffer (H_ACTIVE x 1, read-old-on-write), SHALL be instantiated twice.

Verification
REQ-031 All-zero maze, full frame -> out_valid pulses for exactly 307200 cycles; current=0; up=1 on cy=0 only; left=1 on cx=0 only; right=1 on cx=639 only; down=1 on cy=479 only.
REQ-032 Single wall at (100,50) -> current=1 at (100,50); down=1 at (100,49); up=1 at (100,51); right=1 at (99,50); left=1 at (101,50); all other interior windows 0.
REQ-033 Input (x=1,y=1) -> next cycle CenterX=0, CenterY=0, out_valid=1, up=1, left=1.
REQ-034 Reset pulse at DrawY=200 -> out_valid=0 for the rest of the frame; valid resumes at centre (0,0) of the next frame.
REQ-035 Vertical wall column x=320 for all rows -> right=1 at cx=319 and left=1 at cx=321 on every valid line.
REQ-036 Blanking input mazePix=0 at DrawX=700 -> no line buffer write; centre x=639 still reports right=1.
